// File: rtl/demux1_4.sv
// One-to-four demultiplexer with a one-entry register per output channel.
// Optional per-channel 8-bit transfer counters are enabled with `define DEMUX1_4_CNT_EN.
module demux1_4 #(
    parameter int Width = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [Width-1:0]   in_data_i,
    input  logic [1:0]         in_sel_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [4*Width-1:0] out_data_o,
    output logic [3:0]         out_valid_o,
    input  logic [3:0]         out_ready_i,
    output logic [31:0]        cnt_o
);

    logic [3:0][Width-1:0] data_q, data_d;
    logic [3:0]            valid_q, valid_d;
    logic [3:0]            load, drain;

    // A busy channel still accepts when its consumer drains it in the same cycle.
    assign in_ready_o = !rst_i && (!valid_q[in_sel_i] || out_ready_i[in_sel_i]);

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        load    = '0;
        drain   = valid_q & out_ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            load[in_sel_i] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            valid_d[k] = load[k] || (valid_q[k] && !drain[k]);
            if (load[k]) begin
                data_d[k] = in_data_i;
            end
        end
    end

    // NOTE: the data registers are reset as well, since an empty channel must show 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

`ifdef DEMUX1_4_CNT_EN
    logic [3:0][7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (drain[k]) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_demux1_4.sv
// Directed self-checking bench for demux1_4; expected values are hand-computed.
// Define DEMUX1_4_CNT_EN for both files to exercise the transfer counters.
module tb_demux1_4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  in_data_i;
    logic [1:0]  in_sel_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_valid_o;
    logic [3:0]  out_ready_i;
    logic [31:0] cnt_o;

    int passed = 0;
    int total  = 0;

    demux1_4 #(.Width(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (in_data_i),
        .in_sel_i   (in_sel_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .cnt_o      (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] slice(input logic [31:0] d, input int k);
        return d[k*8 +: 8];
    endfunction

    initial begin
        logic [1:0]  sel;
        logic [31:0] exp_cnt;

        rst_i       = 1'b1;
        in_data_i   = '0;
        in_sel_i    = '0;
        in_valid_i  = 1'b0;
        out_ready_i = '0;
        tick();
        tick();
        check("reset_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("reset_out_valid", {28'd0, out_valid_o}, 32'd0);
        check("reset_out_data", out_data_o, 32'd0);
        check("reset_cnt", cnt_o, 32'd0);

        rst_i = 1'b0;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Single beat to channel 2, held with no consumer.
        in_sel_i = 2'd2; in_data_i = 8'hA5; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("load2_valid", {28'd0, out_valid_o}, 32'h4);
        check("load2_data", out_data_o, 32'h00A5_0000);
        for (int i = 0; i < 5; i++) begin
            in_data_i = 8'(i * 37 + 3);
            in_sel_i  = 2'(i);
            tick();
            check("hold2_valid", {28'd0, out_valid_o}, 32'h4);
            check("hold2_data", out_data_o, 32'h00A5_0000);
        end

        // Drain channel 2; the data slice keeps its last value.
        out_ready_i = 4'b0100;
        tick();
        out_ready_i = 4'b0000;
        check("drain2_valid", {28'd0, out_valid_o}, 32'h0);
        check("drain2_retain", {24'd0, slice(out_data_o, 2)}, 32'hA5);

        // Channel 1 full and stalled: blocks sel=1 but not sel=3.
        in_sel_i = 2'd1; in_data_i = 8'h3C; in_valid_i = 1'b1;
        tick();
        in_data_i = 8'h77;
        #1;
        check("ch1_full_in_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        check("ch1_unchanged", {24'd0, slice(out_data_o, 1)}, 32'h3C);
        in_sel_i = 2'd3; in_data_i = 8'h5A;
        #1;
        check("ch3_free_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        check("ch1_ch3_valid", {28'd0, out_valid_o}, 32'hA);
        check("ch3_data", {24'd0, slice(out_data_o, 3)}, 32'h5A);
        check("ch1_data", {24'd0, slice(out_data_o, 1)}, 32'h3C);

        out_ready_i = 4'b1111;
        tick();
        out_ready_i = 4'b0000;
        check("drain_all_valid", {28'd0, out_valid_o}, 32'h0);

        // Simultaneous drain and load on channel 0.
        in_sel_i = 2'd0; in_data_i = 8'h11; in_valid_i = 1'b1;
        tick();
        out_ready_i = 4'b0001; in_data_i = 8'h22;
        #1;
        check("ch0_pass_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0; out_ready_i = 4'b0000;
        check("ch0_replace_valid", {28'd0, out_valid_o}, 32'h1);
        check("ch0_replace_data", {24'd0, slice(out_data_o, 0)}, 32'h22);
        out_ready_i = 4'b0001;
        tick();
        check("ch0_drained", {28'd0, out_valid_o}, 32'h0);

        // Back-to-back beats across all channels at full rate.
        out_ready_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i);
            in_sel_i = sel; in_data_i = 8'(i + 1); in_valid_i = 1'b1;
            #1;
            check("stream_in_ready", {31'd0, in_ready_o}, 32'd1);
            tick();
            check("stream_valid", {28'd0, out_valid_o}, 32'd1 << sel);
            check("stream_data", {24'd0, slice(out_data_o, int'(sel))}, 32'(i + 1));
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 4'b0000;
        check("stream_empty", {28'd0, out_valid_o}, 32'h0);
`ifdef DEMUX1_4_CNT_EN
        exp_cnt = 32'h0303_0304;
`else
        exp_cnt = 32'h0;
`endif
        check("cnt_after_stream", cnt_o, exp_cnt);

        // Mid-operation reset discards channels 0 and 2; an offered beat is refused.
        in_sel_i = 2'd0; in_data_i = 8'hAA; in_valid_i = 1'b1;
        tick();
        in_sel_i = 2'd2; in_data_i = 8'hBB;
        tick();
        check("pre_reset_valid", {28'd0, out_valid_o}, 32'h5);
        rst_i = 1'b1; in_sel_i = 2'd1; in_data_i = 8'hCC;
        #1;
        check("mid_reset_in_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        rst_i = 1'b0; in_valid_i = 1'b0;
        check("mid_reset_valid", {28'd0, out_valid_o}, 32'h0);
        check("mid_reset_data", out_data_o, 32'h0);
        check("mid_reset_cnt", cnt_o, 32'h0);
        tick();
        check("mid_reset_no_load", {28'd0, out_valid_o}, 32'h0);

        // 257 transfers on channel 3 wrap its counter to 1.
        out_ready_i = 4'b1000; in_sel_i = 2'd3; in_valid_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data_i = 8'(i);
            tick();
        end
        in_valid_i = 1'b0;
        tick();
        check("wrap_empty", {28'd0, out_valid_o}, 32'h0);
`ifdef DEMUX1_4_CNT_EN
        exp_cnt = 32'h0100_0000;
`else
        exp_cnt = 32'h0;
`endif
        check("cnt_wrap", cnt_o, exp_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
